stream_pattern_gen: RTL and testbench
=====================================

# stream_pattern_gen

Parametrised AXI4-Stream test-pattern source, the next-generation replacement for the fixed byte-wide packet generator that feeds the Microblaze streaming path. On each trigger pulse (e.g. the 1 PPS strobe) it emits one packet of configurable length, data width and pattern mode. It honours backpressure and reports completed and dropped packets for ILA/register visibility.

## Interface
Parameters:
- DATA_W, 8: tdata width in bits, 8..32.
- LEN_W, 8: width of pkt_len. A pkt_len of 0 encodes 2^LEN_W beats.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- trigger  in  1  one-cycle start strobe.
- mode  in  2  pattern select, latched at packet start: 0 count, 1 PRBS, 2 fill, 3 walking-one.
- pkt_len  in  LEN_W  payload beats, latched at packet start.
- fill  in  DATA_W  constant for mode 2, latched at packet start.
- m_axis_tdata  out  DATA_W  stream data.
- m_axis_tvalid  out  1  beat valid.
- m_axis_tlast  out  1  final beat of the packet.
- m_axis_tready  in  1  sink ready.
- busy  out  1  high while a packet is in progress.
- pkt_count  out  16  completed packets; wraps at 2^16.
- drop_count  out  8  triggers ignored while busy; saturates at 255.

## Operation
- FSM states:
  - IDLE: trigger=1 latches mode, pkt_len and fill, clears the beat index, then goes to SEND.
  - SEND: presents beats. A beat transfers when tvalid&&tready. On the tlast transfer the FSM returns to IDLE and pkt_count increments.
- A trigger in SEND, including the cycle of the final handshake, increments drop_count (saturating) and is otherwise ignored.
- Beat index idx (LEN_W+1 bits) counts payload beats from 0. tlast=1 when idx == L-1, where L=pkt_len, or 2^LEN_W when pkt_len is 0.
- Payload data, all truncated or zero-extended to DATA_W:
  - mode 0: idx.
  - mode 1: low DATA_W bits of a 32-bit Galois LFSR. Polynomial x^32+x^22+x^2+x+1 (0x80200003), seed 0xFFFFFFFF at reset, advanced once per transferred PRBS beat. The LFSR is not reseeded between packets.
  - mode 2: latched fill.
  - mode 3: 1 << (idx mod DATA_W).
- Changes on mode, pkt_len or fill mid-packet have no effect.

## Timing
- Reset values: tvalid=0, tlast=0, tdata=0, busy=0, pkt_count=0, drop_count=0, FSM=IDLE, LFSR=0xFFFFFFFF.
- Latency: trigger sampled at edge N; tvalid=1 and the first beat are visible after edge N, i.e. in cycle N+1.
- Throughput: one beat per cycle while tready=1.
- While tvalid=1 and tready=0, tdata and tlast are held stable. tvalid never drops before the handshake.
- tvalid and busy go to 0 in the cycle after the tlast handshake. The earliest following trigger is accepted in that cycle, giving a one-cycle idle gap minimum.
- busy equals (FSM==SEND).
- Outputs are registered. There is no combinational path from tready to tvalid or tdata.
- When rst is asserted mid-packet, outputs go immediately to their reset values and the partial packet is abandoned without tlast.

## Configuration
- STREAM_PATTERN_GEN_HEADER_EN defined: each packet starts with one header beat before the payload.
  - Header beat: tdata = pkt_count[DATA_W-1:0] for DATA_W ≤ 16, otherwise zero-extended.
  - Header beat is never tlast.
  - Total beats = L+1.
  - idx and the LFSR do not advance on the header beat.
- Undefined: packets contain payload beats only; total beats = L.

## Test plan
- Reset, then trigger with mode 0, pkt_len=4, tready=1 → beats 0,1,2,3 on cycles N+1..N+4; tlast only on 3; pkt_count=1; busy low at N+5.
- mode 2, fill=0xA5, pkt_len=3, tready toggling 1,0,1,0 → exactly three 0xA5 beats; data held stable on every tready=0 cycle.
- mode 1 after reset, pkt_len=3 → 0xFF, then the next two LFSR low bytes per the reference model; a second packet continues the sequence without reseeding.
- mode 3, pkt_len=0 (256 beats) → pattern 0x01,0x02,…,0x80 repeating; tlast on beat 255 only.
- 300 triggers while busy during one 256-beat packet → drop_count=255 (saturated); pkt_count increments by 1.
- Assert rst mid-packet at beat 2 → tvalid=0 immediately; the next trigger starts a clean packet from idx 0. With STREAM_PATTERN_GEN_HEADER_EN defined, the header beat equals pkt_count.

Source files
------------

// File: rtl/stream_pattern_gen.sv
// rtl/stream_pattern_gen.sv - AXI4-Stream test-pattern packet source (optional header beat: STREAM_PATTERN_GEN_HEADER_EN)
module stream_pattern_gen #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [DATA_W-1:0] fill,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic [15:0]       pkt_count,
  output logic [7:0]        drop_count
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;

  state_t            state, state_next;
  logic [LEN_W:0]    idx;
  logic [LEN_W:0]    idx_inc;
  logic [LEN_W-1:0]  last_q;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] fill_q;
  logic [31:0]       lfsr;
  logic [31:0]       lfsr_step;
  logic              hdr;
  logic              fire;
  logic [LEN_W:0]    adv_idx;
  logic [31:0]       adv_lfsr;
  logic [DATA_W-1:0] adv_walk;
  logic [DATA_W-1:0] adv_data;
  logic              adv_last;
  logic [DATA_W-1:0] start_data;
  logic              start_last;
  logic [31:0]       pkt_count_w;
  logic [DATA_W-1:0] hdr_data;

  // Payload value for one beat given the pattern mode and the beat's context.
  function automatic logic [DATA_W-1:0] payload(input logic [1:0] m, input logic [LEN_W:0] i,
                                                input logic [31:0] l, input logic [DATA_W-1:0] f,
                                                input logic [DATA_W-1:0] w);
    logic [31:0]       iw;
    logic [DATA_W-1:0] d;
    iw = 32'(i);
    case (m)
      2'd0:    d = iw[DATA_W-1:0];
      2'd1:    d = l[DATA_W-1:0];
      2'd2:    d = f;
      default: d = w;
    endcase
    return d;
  endfunction

  assign busy = (state == SEND);

  // Next beat precomputation: outputs are registered, so the value presented after
  // a handshake is built here from the current beat (walking-one rotates the last data).
  always_comb begin
    fire        = m_axis_tvalid && m_axis_tready;
    lfsr_step   = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_POLY : 32'h0);
    idx_inc     = idx + {{LEN_W{1'b0}}, 1'b1};
    adv_idx     = hdr ? idx : idx_inc;
    adv_lfsr    = hdr ? lfsr : lfsr_step;
    adv_walk    = hdr ? DATA_W'(1) : {m_axis_tdata[DATA_W-2:0], m_axis_tdata[DATA_W-1]};
    adv_data    = payload(mode_q, adv_idx, adv_lfsr, fill_q, adv_walk);
    adv_last    = (adv_idx == {1'b0, last_q});
    start_data  = payload(mode, '0, lfsr, fill, DATA_W'(1));
    start_last  = (pkt_len == LEN_W'(1));
    pkt_count_w = {16'h0, pkt_count};
    hdr_data    = pkt_count_w[DATA_W-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state: a trigger opens a packet, the tlast handshake closes it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = SEND;
      SEND:    if (fire && m_axis_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch packet config, present beats, advance index/LFSR, keep counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      last_q        <= '0;
      mode_q        <= 2'd0;
      fill_q        <= '0;
      lfsr          <= LFSR_SEED;
      hdr           <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      pkt_count     <= 16'd0;
      drop_count    <= 8'd0;
    end else begin
      if (state == SEND && trigger && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      if (fire && !hdr && mode_q == 2'd1)
        lfsr <= lfsr_step;
      case (state)
        IDLE: begin
          if (trigger) begin
            mode_q        <= mode;
            fill_q        <= fill;
            last_q        <= pkt_len - LEN_W'(1);
            idx           <= '0;
            m_axis_tvalid <= 1'b1;
`ifdef STREAM_PATTERN_GEN_HEADER_EN
            hdr           <= 1'b1;
            m_axis_tdata  <= hdr_data;
            m_axis_tlast  <= 1'b0;
`else
            hdr           <= 1'b0;
            m_axis_tdata  <= start_data;
            m_axis_tlast  <= start_last;
`endif
          end
        end
        SEND: begin
          if (fire) begin
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              m_axis_tdata  <= '0;
              pkt_count     <= pkt_count + 16'd1;
            end else begin
              hdr           <= 1'b0;
              idx           <= adv_idx;
              m_axis_tdata  <= adv_data;
              m_axis_tlast  <= adv_last;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pattern_gen.sv
// tb/tb_stream_pattern_gen.sv - randomized self-checking bench for stream_pattern_gen
module tb_stream_pattern_gen;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  pkt_len = 8'd0;
  logic [7:0]  fill = 8'd0;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready = 1'b0;
  logic        busy;
  logic [15:0] pkt_count;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_lfsr = 32'hFFFF_FFFF;
  int          m_pkt = 0;
  int          m_drop = 0;
  logic [7:0]  exp_q[$];

  stream_pattern_gen #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .mode(mode), .pkt_len(pkt_len), .fill(fill),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tready(tready),
    .busy(busy), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] prbs_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Triggers one packet at the current negedge and follows it to completion.
  // style: 0 tready always 1, 1 toggling 1,0,1,0..., 2 random. hold_trig keeps trigger high.
  task automatic send_pkt(input logic [1:0] m, input int len, input logic [7:0] f,
                          input int style, input bit hold_trig);
    int n, k, cycles;
    logic [7:0] hd;
    logic hl, rdy;
    bit stall;
    n = (len == 0) ? 256 : len;
    exp_q.delete();
`ifdef STREAM_PATTERN_GEN_HEADER_EN
    exp_q.push_back(8'(m_pkt));
`endif
    for (int i = 0; i < n; i++) begin
      case (m)
        2'd0: exp_q.push_back(8'(i));
        2'd1: begin exp_q.push_back(m_lfsr[7:0]); m_lfsr = prbs_next(m_lfsr); end
        2'd2: exp_q.push_back(f);
        default: exp_q.push_back(8'(1 << (i % DATA_W)));
      endcase
    end
    mode = m; pkt_len = 8'(len); fill = f; trigger = 1'b1; tready = 1'b0;
    @(negedge clk);
    trigger = hold_trig;
    checks++;
    if (tvalid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL latency: tvalid=%b busy=%b, expected 1 1", tvalid, busy);
    end
    k = 0; cycles = 0; stall = 0; hd = '0; hl = 1'b0;
    while (k < exp_q.size() && cycles < 3000) begin
      mode = 2'($urandom); pkt_len = 8'($urandom); fill = 8'($urandom);
      case (style)
        0: rdy = 1'b1;
        1: rdy = (cycles % 2 == 0);
        default: rdy = 1'($urandom);
      endcase
      tready = rdy;
      checks++;
      if (tvalid !== 1'b1) begin
        errors++; $display("FAIL valid_hold: tvalid=%b at beat %0d, expected 1", tvalid, k);
      end
      if (stall) begin
        checks++;
        if (tdata !== hd || tlast !== hl) begin
          errors++; $display("FAIL stall_stable: tdata=%h tlast=%b, expected %h %b", tdata, tlast, hd, hl);
        end
      end
      if (rdy) begin
        checks++;
        if (tdata !== exp_q[k] || tlast !== (k == exp_q.size() - 1)) begin
          errors++; $display("FAIL beat %0d: tdata=%h tlast=%b, expected %h %b",
                             k, tdata, tlast, exp_q[k], (k == exp_q.size() - 1));
        end
        k++;
      end
      stall = !rdy; hd = tdata; hl = tlast;
      if (hold_trig && m_drop < 255) m_drop++;
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (k != exp_q.size()) begin
      errors++; $display("FAIL timeout: %0d beats seen, expected %0d", k, exp_q.size());
    end
    trigger = 1'b0;
    m_pkt++;
    checks++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || tlast !== 1'b0) begin
      errors++; $display("FAIL idle_after: tvalid=%b busy=%b tlast=%b, expected 0 0 0", tvalid, busy, tlast);
    end
    checks++;
    if (pkt_count !== 16'(m_pkt)) begin
      errors++; $display("FAIL pkt_count: %0d, expected %0d", pkt_count, m_pkt);
    end
    checks++;
    if (drop_count !== 8'(m_drop)) begin
      errors++; $display("FAIL drop_count: %0d, expected %0d", drop_count, m_drop);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 8'h00 || busy !== 1'b0 ||
        pkt_count !== 16'd0 || drop_count !== 8'd0) begin
      errors++; $display("FAIL reset_state: tvalid=%b tlast=%b tdata=%h busy=%b pkt=%0d drop=%0d, expected all 0",
                         tvalid, tlast, tdata, busy, pkt_count, drop_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_no_trigger: tvalid=%b busy=%b, expected 0 0", tvalid, busy);
    end
  endtask

  task automatic test_count();
    send_pkt(2'd0, 4, 8'h00, 0, 1'b0);
  endtask

  task automatic test_fill_backpressure();
    send_pkt(2'd2, 3, 8'hA5, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    mode = 2'd0; pkt_len = 8'd10; fill = 8'h00; tready = 1'b1; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (2) @(negedge clk);
`ifdef STREAM_PATTERN_GEN_HEADER_EN
    @(negedge clk);
`endif
    checks++;
    if (tvalid !== 1'b1 || tdata !== 8'd2) begin
      errors++; $display("FAIL pre_reset_beat: tvalid=%b tdata=%h, expected 1 02", tvalid, tdata);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: tvalid=%b tlast=%b tdata=%h busy=%b, expected 0 0 00 0",
                         tvalid, tlast, tdata, busy);
    end
    checks++;
    if (pkt_count !== 16'd0 || drop_count !== 8'd0) begin
      errors++; $display("FAIL reset_counters: pkt=%0d drop=%0d, expected 0 0", pkt_count, drop_count);
    end
    m_pkt = 0; m_drop = 0; m_lfsr = 32'hFFFF_FFFF;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_pkt(2'd0, 5, 8'h00, 0, 1'b0);
  endtask

  task automatic test_prbs();
    send_pkt(2'd1, 3, 8'h00, 0, 1'b0);
    send_pkt(2'd1, 5, 8'h00, 2, 1'b0);
  endtask

  task automatic test_walking();
    send_pkt(2'd3, 0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_drop_saturate();
    send_pkt(2'($urandom), 0, 8'($urandom), 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int p = 0; p < 10; p++)
      send_pkt(2'($urandom), int'($urandom_range(1, 12)), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
  endtask

  initial begin
    test_reset();
    test_count();
    test_fill_backpressure();
    test_reset_mid();
    test_prbs();
    test_walking();
    test_drop_saturate();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
